// File: rtl/boot_sram_resp_pkg.sv
// Shared definitions for the boot SRAM responder slice.
// Load-monitor state encoding, kept here so status decoders can reuse it.
package boot_sram_resp_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LOADING = 2'd1;
   localparam logic [1:0] ST_DONE    = 2'd2;

endpackage

// File: rtl/boot_load_mon.sv
// Boot load monitor: tracks words written, running checksum and load completion.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no load seen since reset; counters hold
// ST_LOADING | boot stream active; counting words and summing full words
// ST_DONE    | stream ended; load_done=1, counters hold until a reboot
module boot_load_mon
   import boot_sram_resp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                boot_valid,
   input  logic [DATA_W-1:0]   boot_wdata,
   input  logic [DATA_W/8-1:0] boot_wstrb,
   output logic                load_done,
   output logic [CNT_W-1:0]    load_cnt,
   output logic [DATA_W-1:0]   load_sum
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       full_word;
   logic       load_start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (boot_valid)  state_nxt = ST_LOADING;
         ST_LOADING: if (!boot_valid) state_nxt = ST_DONE;
         ST_DONE:    if (boot_valid)  state_nxt = ST_LOADING;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      load_done  = (state == ST_DONE);
      load_start = boot_valid && (state != ST_LOADING);
      full_word  = &boot_wstrb;
   end

   // A new load restarts the count with the current word already included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_cnt <= '0;
         load_sum <= '0;
      end else if (boot_valid) begin
         if (load_start) begin
            load_cnt <= CNT_W'(1);
            load_sum <= full_word ? boot_wdata : '0;
         end else begin
            if (!(&load_cnt)) load_cnt <= load_cnt + 1'b1;
            if (full_word)    load_sum <= load_sum + boot_wdata;
         end
      end
   end

endmodule

// File: rtl/boot_sram_resp.sv
// Arbitrates the boot write stream and the CPU port onto one SRAM macro port.
// Boot always wins; a CPU access completes one cycle after it reaches the macro.
module boot_sram_resp #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int SRAM_ADDR_W = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     boot_valid,
   input  logic [ADDR_W-1:0]        boot_addr,
   input  logic [DATA_W-1:0]        boot_wdata,
   input  logic [DATA_W/8-1:0]      boot_wstrb,
   input  logic                     cpu_valid,
   input  logic [ADDR_W-1:0]        cpu_addr,
   input  logic [DATA_W-1:0]        cpu_wdata,
   input  logic [DATA_W/8-1:0]      cpu_wstrb,
   output logic [DATA_W-1:0]        cpu_rdata,
   output logic                     cpu_ready,
   output logic                     mem_en,
   output logic [DATA_W/8-1:0]      mem_we,
   output logic [SRAM_ADDR_W-3:0]   mem_addr,
   output logic [DATA_W-1:0]        mem_din,
   input  logic [DATA_W-1:0]        mem_dout,
   output logic                     load_done,
   output logic [SRAM_ADDR_W-2:0]   load_cnt,
   output logic [DATA_W-1:0]        load_sum
);

   logic boot_win;
   logic cpu_acc;
   logic pend;
   logic unused_addr_bits;

   // Macro access is suppressed while rst is held so nothing reaches the SRAM.
   always_comb begin
      boot_win = boot_valid && !rst;
      cpu_acc  = cpu_valid && !boot_valid && !pend && !rst;
   end

   always_comb begin
      mem_en   = 1'b0;
      mem_we   = '0;
      mem_addr = '0;
      mem_din  = '0;
      if (boot_win) begin
         mem_en   = 1'b1;
         mem_we   = boot_wstrb;
         mem_addr = boot_addr[SRAM_ADDR_W-1:2];
         mem_din  = boot_wdata;
      end else if (cpu_acc) begin
         mem_en   = 1'b1;
         mem_we   = cpu_wstrb;
         mem_addr = cpu_addr[SRAM_ADDR_W-1:2];
         mem_din  = cpu_wdata;
      end
   end

   // High address bits are dropped on purpose: offsets wrap within the SRAM.
   assign unused_addr_bits = ^{boot_addr[ADDR_W-1:SRAM_ADDR_W], boot_addr[1:0],
                               cpu_addr[ADDR_W-1:SRAM_ADDR_W], cpu_addr[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend <= 1'b0;
      else     pend <= cpu_acc;
   end

   assign cpu_ready = pend;
   assign cpu_rdata = pend ? mem_dout : '0;

   boot_load_mon #(
      .DATA_W (DATA_W),
      .CNT_W  (SRAM_ADDR_W-1)
   ) u_load_mon (
      .clk        (clk),
      .rst        (rst),
      .boot_valid (boot_valid),
      .boot_wdata (boot_wdata),
      .boot_wstrb (boot_wstrb),
      .load_done  (load_done),
      .load_cnt   (load_cnt),
      .load_sum   (load_sum)
   );

endmodule

// File: tb/tb_boot_sram_resp.sv
// Directed bench for boot_sram_resp with an SRAM model and a CPU response scoreboard.
module tb_boot_sram_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        boot_valid;
   logic [31:0] boot_addr;
   logic [31:0] boot_wdata;
   logic [3:0]  boot_wstrb;
   logic        cpu_valid;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_wstrb;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [12:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        load_done;
   logic [13:0] load_cnt;
   logic [31:0] load_sum;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
   } sb_item_t;

   sb_item_t    sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sram [0:8191];

   always #5 clk = ~clk;

   boot_sram_resp dut (
      .clk        (clk),
      .rst        (rst),
      .boot_valid (boot_valid),
      .boot_addr  (boot_addr),
      .boot_wdata (boot_wdata),
      .boot_wstrb (boot_wstrb),
      .cpu_valid  (cpu_valid),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_wstrb  (cpu_wstrb),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout),
      .load_done  (load_done),
      .load_cnt   (load_cnt),
      .load_sum   (load_sum)
   );

   // Synchronous-read SRAM macro model.
   always @(posedge clk) begin
      if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
         if (mem_we == 4'h0) mem_dout <= sram[mem_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; any completion is matched against the scoreboard.
   task automatic tick();
      sb_item_t it;
      @(posedge clk);
      #1;
      if (cpu_ready === 1'b1) begin
         n_tests++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected_ready: observed ready=1 expected no ready");
         end
         if (sb.size() != 0) begin
            it = sb.pop_front();
            if (it.is_read) check("sb_rdata", cpu_rdata, it.data);
         end
      end
   endtask

   task automatic boot(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
      boot_valid = v;
      boot_addr  = a;
      boot_wdata = d;
      boot_wstrb = s;
   endtask

   task automatic cpu(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
      cpu_valid = v;
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_wstrb = s;
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) sram[i] = 32'h0;
      mem_dout = 32'h0;
   end

   initial begin
      rst = 1'b1;
      boot(1'b0, 32'h0, 32'h0, 4'h0);
      cpu(1'b0, 32'h0, 32'h0, 4'h0);
      #3;
      check("rst_cpu_ready", cpu_ready, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_load_done", load_done, 0);
      check("rst_load_cnt", load_cnt, 0);
      check("rst_load_sum", load_sum, 0);
      check("rst_mem_en", mem_en, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // Boot burst 1..4 at 0x7C00..0x7C0C
      for (int i = 0; i < 4; i++) begin
         boot(1'b1, 32'h7C00 + 32'(4*i), 32'(i+1), 4'hF);
         #1;
         check("burst_mem_en", mem_en, 1);
         check("burst_mem_addr", mem_addr, 32'h1F00 + 32'(i));
         check("burst_mem_we", mem_we, 4'hF);
         tick();
      end
      boot(1'b0, 32'h0, 32'h0, 4'h0);
      check("burst_done_not_yet", load_done, 0);
      check("burst_cnt", load_cnt, 4);
      check("burst_sum", load_sum, 10);
      #1;
      check("idle_mem_en", mem_en, 0);
      tick();
      check("burst_done", load_done, 1);

      // CPU read of 0x7C04, held across the ready cycle
      cpu(1'b1, 32'h7C04, 32'h0, 4'h0);
      #1;
      check("rd_mem_en", mem_en, 1);
      check("rd_mem_we", mem_we, 0);
      check("rd_mem_addr", mem_addr, 32'h1F01);
      sb.push_back('{is_read: 1'b1, data: 32'd2});
      tick();
      check("rd_ready", cpu_ready, 1);
      check("rd_pend_blocks_macro", mem_en, 0);
      tick();
      check("rd_ready_single", cpu_ready, 0);
      cpu(1'b0, 32'h0, 32'h0, 4'h0);
      tick();

      // CPU write over a boot word, then read back: last write wins
      cpu(1'b1, 32'h7C00, 32'h0000_0055, 4'hF);
      #1;
      check("wr_mem_we", mem_we, 4'hF);
      check("wr_mem_din", mem_din, 32'h55);
      sb.push_back('{is_read: 1'b0, data: 32'h0});
      tick();
      check("wr_ready", cpu_ready, 1);
      cpu(1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      cpu(1'b1, 32'h7C00, 32'h0, 4'h0);
      sb.push_back('{is_read: 1'b1, data: 32'h55});
      tick();
      check("rdback_ready", cpu_ready, 1);
      cpu(1'b0, 32'h0, 32'h0, 4'h0);
      tick();

      // CPU stalls behind a 3-word boot burst
      cpu(1'b1, 32'h7C08, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         boot(1'b1, 32'h100 + 32'(4*i), 32'(7+i), 4'hF);
         #1;
         check("stall_boot_we", mem_we, 4'hF);
         check("stall_boot_addr", mem_addr, 32'h40 + 32'(i));
         tick();
         check("stall_no_ready", cpu_ready, 0);
      end
      boot(1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      check("stall_acc_en", mem_en, 1);
      check("stall_acc_we", mem_we, 0);
      check("stall_acc_addr", mem_addr, 32'h1F02);
      sb.push_back('{is_read: 1'b1, data: 32'd3});
      tick();
      check("stall_ready", cpu_ready, 1);
      cpu(1'b0, 32'h0, 32'h0, 4'h0);
      check("stall_load_done", load_done, 1);
      check("stall_load_cnt", load_cnt, 3);
      check("stall_load_sum", load_sum, 24);
      tick();

      // Partial-strobe word counts but does not enter the checksum
      boot(1'b1, 32'h300, 32'd5, 4'hF);
      tick();
      check("part_cnt1", load_cnt, 1);
      check("part_sum1", load_sum, 5);
      boot(1'b1, 32'h304, 32'h0000_FFFF, 4'h3);
      #1;
      check("part_mem_we", mem_we, 4'h3);
      tick();
      check("part_cnt2", load_cnt, 2);
      check("part_sum2", load_sum, 5);
      boot(1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      check("part_done", load_done, 1);

      // Reboot with 5,5 after DONE
      boot(1'b1, 32'h400, 32'd5, 4'hF);
      #1;
      check("reboot_done_held", load_done, 1);
      tick();
      check("reboot_done_drop", load_done, 0);
      check("reboot_cnt1", load_cnt, 1);
      boot(1'b1, 32'h404, 32'd5, 4'hF);
      tick();
      check("reboot_cnt2", load_cnt, 2);
      check("reboot_sum", load_sum, 10);
      boot(1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      check("reboot_done", load_done, 1);

      // Reset mid-burst with a CPU read just accepted
      boot(1'b1, 32'h500, 32'd9, 4'hF);
      tick();
      check("rstmid_cnt", load_cnt, 1);
      boot(1'b0, 32'h0, 32'h0, 4'h0);
      cpu(1'b1, 32'h7C04, 32'h0, 4'h0);
      #1;
      check("rstmid_acc", mem_en, 1);
      rst = 1'b1;
      #1;
      check("rstmid_mem_en", mem_en, 0);
      check("rstmid_ready", cpu_ready, 0);
      check("rstmid_rdata", cpu_rdata, 0);
      check("rstmid_load_cnt", load_cnt, 0);
      check("rstmid_load_sum", load_sum, 0);
      check("rstmid_load_done", load_done, 0);
      tick();
      check("rstmid_no_ready", cpu_ready, 0);
      cpu(1'b0, 32'h0, 32'h0, 4'h0);
      rst = 1'b0;
      tick();
      check("post_rst_ready", cpu_ready, 0);
      check("post_rst_done", load_done, 0);
      boot(1'b1, 32'h600, 32'd6, 4'hF);
      tick();
      check("fresh_cnt", load_cnt, 1);
      check("fresh_sum", load_sum, 6);
      boot(1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      check("fresh_done", load_done, 1);
      check("sb_drained", 32'(sb.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/boot_sram_resp.md
# boot_sram_resp

SRAM-side responder for the boot loader's master write stream and the CPU's native memory port. It arbitrates both onto a single synchronous-read SRAM macro port, giving boot writes absolute priority because the boot stream has no back-pressure. It also tracks the load: word count, running checksum and a load-done flag for boot-status readback. It sits between the boot controller / CPU internal bus and the SRAM macro.

## Interface
Parameters:
- DATA_W, 32, data width (multiple of 8)
- ADDR_W, 32, byte-address width of both request ports
- SRAM_ADDR_W, 15, SRAM byte-address width; macro is word-addressed with SRAM_ADDR_W-2 bits

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- boot_valid  in  1  boot write request; no ready, must be taken in the same cycle
- boot_addr  in  ADDR_W  boot byte address
- boot_wdata  in  DATA_W  boot write data
- boot_wstrb  in  DATA_W/8  boot byte strobes
- cpu_valid  in  1  CPU request, held until cpu_ready
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_wstrb  in  DATA_W/8  CPU strobes; 0 = read
- cpu_rdata  out  DATA_W  read data, valid with cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- mem_en  out  1  macro enable
- mem_we  out  DATA_W/8  macro byte write enables
- mem_addr  out  SRAM_ADDR_W-2  macro word address
- mem_din  out  DATA_W  macro write data
- mem_dout  in  DATA_W  macro read data, one cycle after mem_en with mem_we=0
- load_done  out  1  boot load complete
- load_cnt  out  SRAM_ADDR_W-1  boot words written since the last load start
- load_sum  out  DATA_W  sum mod 2^DATA_W of boot_wdata for full-strobe boot writes

## Operation
- Macro port is combinational from the winning request. Word address = byte address bits [SRAM_ADDR_W-1:2]. Upper address bits are discarded, so negative-offset boot addresses wrap into the top of the SRAM by design.
- Boot wins whenever boot_valid=1: mem_en=1, mem_we=boot_wstrb, mem_din=boot_wdata.
- CPU is accepted when cpu_valid & ~boot_valid & ~pend:
  - mem_en=1, mem_we=cpu_wstrb, mem_din=cpu_wdata.
  - pend is set for exactly one cycle.
- A CPU request blocked by boot_valid stalls: no macro access, cpu_ready stays 0. It is retried every cycle until boot_valid=0.
- Completion: cpu_ready=pend. cpu_rdata=mem_dout when pend=1, otherwise 0. Writes also complete with cpu_ready; rdata content is don't-care for writes.
- Load FSM (reset state IDLE):
  - IDLE -> LOADING on boot_valid. Clears load_cnt/load_sum, then accumulates the current word.
  - LOADING: each boot_valid cycle increments load_cnt (saturating at all-ones). If boot_wstrb is all-ones, load_sum += boot_wdata.
  - LOADING -> DONE on the first cycle with boot_valid=0.
  - DONE -> LOADING on boot_valid (reboot): restart counting exactly as from IDLE.
- load_done=1 only in DONE. load_cnt and load_sum hold their values in DONE and IDLE.

## Timing
- Reset values: cpu_ready=0, cpu_rdata=0, load_done=0, load_cnt=0, load_sum=0, pend=0, FSM=IDLE. mem_en=0 whenever neither port wins.
- CPU latency: request accepted at cycle t -> cpu_ready at t+1. Maximum throughput is one CPU access per 2 cycles.
- Boot write at t+1 colliding with a pending CPU read: the read still returns the cycle-t macro data. Macro dout reflects the previous cycle's read.
- Simultaneous boot_valid and cpu_valid: boot wins and the CPU stalls. There is no starvation bound; the boot stream is finite.
- Boot write and CPU write to the same word in different cycles: last write wins, no hazard logic.
- Load counters update at the clock edge ending the boot write cycle. load_done rises one cycle after the last boot write.
- rst mid-load or mid-CPU-access: immediate return to reset values. An in-flight CPU request gets no ready; the master re-issues it after reset.

## Structure
- No shared package required. Width expressions stay local; the FSM state encoding is a localparam (2 bits).
- One natural sub-module: boot_load_mon, containing the load FSM, count and checksum. Arbitration and pend remain in the top. Registers use the existing iob_reg where convenient.

## Test plan
- Boot burst of 4 full-strobe words (1,2,3,4) at byte addresses 0x7C00..0x7C0C -> mem_addr 0x1F00..0x1F03. load_done rises one cycle after the last word, load_cnt=4, load_sum=10.
- CPU read of address 0x7C04 after the load -> cpu_ready one cycle later with cpu_rdata=2. cpu_ready is not repeated while cpu_valid is held.
- cpu_valid asserted during a 3-cycle boot burst -> no CPU macro access and cpu_ready=0 for 3 cycles; accepted on cycle 4, ready on cycle 5.
- Boot write with wstrb=0x3 -> load_cnt increments, load_sum unchanged, mem_we=0x3.
- Second boot burst of 2 words (5,5) after DONE -> load_done drops, then load_cnt=2, load_sum=10.
- rst asserted mid-burst with a CPU read pending -> all outputs return to reset values immediately and no cpu_ready is issued. A fresh burst is counted from 0.
